// File: rtl/lfsr_uart_streamer.sv
// lfsr_uart_streamer
// Galois LFSR with runtime taps. Each LFSR word is sent as uppercase hex
// ASCII (MS nibble first, optionally followed by CR LF) on a UART TX line.
// Ports:
//   clk, reset (async, active-high)
//   enable      continuous mode: words back-to-back while high
//   start       one-cycle request for a single word
//   taps        Galois feedback mask, used at each LFSR step
//   seed_load   load seed_value into the LFSR (only while idle)
//   seed_value  value for seed_load (zero is forced to 1)
//   tx          UART line, idle high
//   busy        high from word acceptance until back in IDLE
//   word_done   one-cycle pulse while the LFSR steps after a word
//   lfsr_state  current LFSR register
module lfsr_uart_streamer #(
  parameter int LFSR_W      = 16,
  parameter int SEED        = 1,
  parameter int BAUD_DIV    = 5208,
  parameter int STOP_BITS   = 1,
  parameter int APPEND_CRLF = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [LFSR_W-1:0] taps,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_value,
  output logic              tx,
  output logic              busy,
  output logic              word_done,
  output logic [LFSR_W-1:0] lfsr_state
);
  localparam int ND = (LFSR_W + 3) / 4;
  localparam int NC = ND + 2 * APPEND_CRLF;
  localparam int PW = 4 * ND;
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(NC + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_ADV} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [CW-1:0]     char_q, char_d;
  logic [LFSR_W-1:0] word_q, word_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  logic [PW-1:0]     wpad;
  logic [3:0]        nib;
  logic [7:0]        cur_char;
  logic [LFSR_W-1:0] step_v;
  logic              baud_last;

  // The all-zero state is a lock-up point for the LFSR, so it never enters it.
  function automatic logic [LFSR_W-1:0] nz(input logic [LFSR_W-1:0] v);
    return (v == '0) ? LFSR_W'(1) : v;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      char_q  <= '0;
      word_q  <= '0;
      lfsr_q  <= LFSR_W'(SEED);
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      word_q  <= word_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Character under transmission: hex digits of the snapshot word, then CR LF.
  always_comb begin
    wpad     = PW'(word_q);
    nib      = 4'h0;
    cur_char = 8'h0A;
    for (int d = 0; d < ND; d++)
      if (char_q == CW'(ND - 1 - d)) nib = wpad[4*d +: 4];
    if (char_q < CW'(ND))
      cur_char = (nib < 4'd10) ? {4'h3, nib} : 8'h37 + {4'h0, nib};
    else if (char_q == CW'(ND))
      cur_char = 8'h0D;
  end

  assign step_v    = lfsr_q[0] ? ((lfsr_q >> 1) ^ taps) : (lfsr_q >> 1);
  assign baud_last = (baud_q == BW'(BAUD_DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    char_d  = char_q;
    word_d  = word_q;
    lfsr_d  = lfsr_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          lfsr_d = nz(seed_value);
        end else if (enable | start) begin
          state_d = S_START;
          word_d  = lfsr_q;
          char_d  = '0;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (char_q < CW'(NC - 1)) begin
              char_d  = char_q + CW'(1);
              state_d = S_START;
            end else begin
              state_d = S_ADV;
            end
          end
        end
      end
      S_ADV: begin
        lfsr_d  = nz(step_v);
        char_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset forces tx high at once.
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = cur_char[bit_q];
      default: tx = 1'b1;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign word_done  = (state_q == S_ADV);
  assign lfsr_state = lfsr_q;

endmodule
